// File: rtl/alu_pkg.sv
// Shared opcode definitions for the queued ALU engine.
// Widening OP_W opens up reserved codes that raise err_op.
package alu_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 'd0,
    OP_SUB = 'd1,
    OP_AND = 'd2,
    OP_OR  = 'd3,
    OP_EQ  = 'd4,
    OP_GT  = 'd5,
    OP_LT  = 'd6,
    OP_NE  = 'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Pushes while full are ignored; pops while empty are ignored.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/alu_queue_engine.sv
// Instruction FIFO feeding a one-stage ALU with a held output
// register; results retire under a valid/ready handshake.
module alu_queue_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               op_in,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     cout,
  output logic                     ovf,
  output logic [WIDTH-1:0]         a_out,
  output logic [WIDTH-1:0]         b_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_op
);
  localparam int DW = OP_W + 2 * WIDTH;

  logic [DW-1:0]    head;
  logic             full, empty, pop;
  logic [OP_W-1:0]  hop;
  logic [WIDTH-1:0] ha, hb;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_d;
  logic             cout_d, ovf_d, err_d;

  state_e           state_q;
  logic             out_valid_q, cout_q, ovf_q, err_q;
  logic [WIDTH-1:0] result_q, a_q, b_q;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .din   ({OP_W'(op_in), a_in, b_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign in_ready = ~full;
  assign hop      = head[DW-1 -: OP_W];
  assign ha       = head[2*WIDTH-1 -: WIDTH];
  assign hb       = head[WIDTH-1:0];
  // Pop uses the pre-push level, so a word pushed into an empty FIFO waits a cycle.
  assign pop      = ~empty & ((state_q == IDLE) | out_ready);

  always_comb begin
    sum    = {1'b0, ha} + {1'b0, hb};
    diff   = {1'b0, ha} - {1'b0, hb};
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    err_d  = 1'b0;
    case (op_e'(hop))
      OP_ADD: begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        ovf_d  = (ha[WIDTH-1] == hb[WIDTH-1]) &&
                 (sum[WIDTH-1] != ha[WIDTH-1]);
      end
      OP_SUB: begin
        res_d  = diff[WIDTH-1:0];
        cout_d = diff[WIDTH];
        ovf_d  = (ha[WIDTH-1] != hb[WIDTH-1]) &&
                 (diff[WIDTH-1] != ha[WIDTH-1]);
      end
      OP_AND: res_d = ha & hb;
      OP_OR:  res_d = ha | hb;
      OP_EQ:  res_d = WIDTH'(ha == hb);
      OP_GT:  res_d = WIDTH'(ha > hb);
      OP_LT:  res_d = WIDTH'(ha < hb);
      OP_NE:  res_d = WIDTH'(ha != hb);
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (pop) begin
        state_q     <= HOLD;
        out_valid_q <= 1'b1;
        result_q    <= res_d;
        cout_q      <= cout_d;
        ovf_q       <= ovf_d;
        a_q         <= ha;
        b_q         <= hb;
        err_q       <= err_d;
      end else if (state_q == HOLD && out_ready) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign err_op    = err_q;
endmodule

// File: tb/tb_alu_queue_engine.sv
// Scoreboard bench for alu_queue_engine (WIDTH=6, DEPTH=16).
// Stimulus queues expectations; a negedge monitor retires them.
module tb_alu_queue_engine;
  localparam int W  = 6;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    op_in;
  logic [W-1:0]  a_in, b_in;
  logic          out_valid, out_ready;
  logic [W-1:0]  result, a_out, b_out;
  logic          cout, ovf, err_op;
  logic [LW-1:0] level;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  exp_t sb[$];
  exp_t got;
  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;

  alu_queue_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op_in     (op_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .a_out     (a_out),
    .b_out     (b_out),
    .level     (level),
    .err_op    (err_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: retire one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_out: got r=0x%0h a=0x%0h b=0x%0h, expected none",
                 result, a_out, b_out);
      end else begin
        got = sb.pop_front();
        chk("out", 32'({result, cout, ovf, a_out, b_out, err_op}),
            32'({got.r, got.c, got.o, got.a, got.b, 1'b0}));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input exp_t e,
                       output logic acc);
    in_valid = 1'b1;
    op_in    = op;
    a_in     = e.a;
    b_in     = e.b;
    @(negedge clk);
    acc = in_ready;
    if (acc) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_idle", 32'({out_valid, level}), 32'd0);
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sbv, s, ss;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 32) ? ua - 64 : ua;
    sbv = (ub >= 32) ? ub - 64 : ub;
    e.a = a;
    e.b = b;
    e.c = 1'b0;
    e.o = 1'b0;
    e.r = '0;
    case (op)
      3'd0: begin
        s   = ua + ub;
        ss  = sa + sbv;
        e.r = W'(s & 63);
        e.c = (s > 63);
        e.o = (ss > 31) || (ss < -32);
      end
      3'd1: begin
        s   = ua - ub;
        ss  = sa - sbv;
        e.r = W'(s & 63);
        e.c = (ua < ub);
        e.o = (ss > 31) || (ss < -32);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = W'(ua == ub);
      3'd5: e.r = W'(ua > ub);
      3'd6: e.r = W'(ua < ub);
      default: e.r = W'(ua != ub);
    endcase
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    exp_t e;
    logic [2:0] op;

    vecs = '{
      '{3'd0, 6'h19, 6'h28, 6'h01, 1'b1, 1'b0},
      '{3'd1, 6'h05, 6'h09, 6'h3C, 1'b1, 1'b0},
      '{3'd6, 6'h05, 6'h09, 6'h01, 1'b0, 1'b0},
      '{3'd0, 6'h1F, 6'h01, 6'h20, 1'b0, 1'b1},
      '{3'd1, 6'h20, 6'h01, 6'h1F, 1'b0, 1'b1},
      '{3'd2, 6'h3C, 6'h0F, 6'h0C, 1'b0, 1'b0},
      '{3'd3, 6'h30, 6'h05, 6'h35, 1'b0, 1'b0},
      '{3'd4, 6'h07, 6'h07, 6'h01, 1'b0, 1'b0},
      '{3'd4, 6'h07, 6'h08, 6'h00, 1'b0, 1'b0},
      '{3'd5, 6'h3F, 6'h01, 6'h01, 1'b0, 1'b0},
      '{3'd7, 6'h03, 6'h03, 6'h00, 1'b0, 1'b0},
      '{3'd0, 6'h3F, 6'h3F, 6'h3E, 1'b1, 1'b0},
      '{3'd1, 6'h09, 6'h05, 6'h04, 1'b0, 1'b0},
      '{3'd5, 6'h01, 6'h3F, 6'h00, 1'b0, 1'b0},
      '{3'd6, 6'h3F, 6'h01, 6'h00, 1'b0, 1'b0},
      '{3'd7, 6'h03, 6'h04, 6'h01, 1'b0, 1'b0}
    };

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_in     = '0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs",
        32'({out_valid, result, cout, ovf, a_out, b_out, err_op, level}),
        32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed table, back-to-back with the consumer always ready.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      e = '{vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].a, vecs[i].b};
      issue(vecs[i].op, e, acc);
      chk("dir_accept", 32'(acc), 32'd1);
    end
    drain();

    // Fill: one held in the output register plus DEPTH in the FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      e = '{W'(i + 1), 1'b0, 1'b0, W'(i), 6'h01};
      issue(3'd0, e, acc);
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_hold", 32'(out_valid), 32'd1);
    e = '{6'h2B, 1'b0, 1'b0, 6'h2A, 6'h01};
    issue(3'd0, e, acc);
    chk("drop18_acc", 32'(acc), 32'd0);
    chk("drop18_level", 32'(level), 32'd16);

    // Push and pop together at full: the push sees in_ready=0.
    out_ready = 1'b1;
    e = '{6'h15, 1'b0, 1'b0, 6'h14, 6'h01};
    issue(3'd0, e, acc);
    chk("fullpp_acc", 32'(acc), 32'd0);
    chk("fullpp_level", 32'(level), 32'd15);
    for (int i = 0; i < 3; i++) begin
      e = '{W'(8'h22 + i), 1'b0, 1'b0, W'(8'h21 + i), 6'h01};
      issue(3'd0, e, acc);
      chk("pp_acc", 32'(acc), 32'd1);
      chk("pp_level", 32'(level), 32'd15);
    end
    drain();

    // Pseudo-random stream with a stalling consumer.
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      e  = model(op, W'($urandom_range(0, 63)), W'($urandom_range(0, 63)));
      issue(op, e, acc);
    end
    drain();

    // Asynchronous reset with level=5 and a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = '{W'(i + 2), 1'b0, 1'b0, W'(i), 6'h02};
      issue(3'd0, e, acc);
    end
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst",
        32'({out_valid, result, cout, ovf, a_out, b_out, err_op, level}),
        32'd0);
    sb.delete();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst",
        32'({in_ready, out_valid, level}), 32'({1'b1, 1'b0, 5'd0}));
    out_ready = 1'b1;
    e = '{6'h3C, 1'b1, 1'b0, 6'h05, 6'h09};
    issue(3'd1, e, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
